// File: rtl/div_unit.sv
// div_unit: multi-cycle restoring integer divider, UNROLL quotient bits per cycle,
// signed/unsigned, with divide-by-zero flag and busy/ready handshake.
module div_unit #(
  parameter int WIDTH  = 32,
  parameter int UNROLL = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_in,
  input  logic               annul_in,
  input  logic               signed_div_in,
  input  logic [WIDTH-1:0]   opdata1_in,
  input  logic [WIDTH-1:0]   opdata2_in,
  output logic [2*WIDTH-1:0] result_out,
  output logic               ready_out,
  output logic               busy_out,
  output logic               div_zero_out
);
  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] STEP = CW'(UNROLL);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - UNROLL);
  typedef enum logic [1:0] {IDLE, BYZERO, ON, END} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [WIDTH:0] rem_q, rem_d, r;
  logic [WIDTH-1:0] quo_q, quo_d, dvs_q, dvs_d, q, q_fix, r_fix;
  logic neg_q, neg_d, rsgn_q, rsgn_d, ge;
  logic [2*WIDTH-1:0] res_q, res_d;
  logic ready_q, ready_d, busy_q, busy_d, dz_q, dz_d;
  logic a_neg, b_neg;
  assign a_neg = signed_div_in & opdata1_in[WIDTH-1];
  assign b_neg = signed_div_in & opdata2_in[WIDTH-1];
  // UNROLL restoring steps; the partial remainder never exceeds the divisor, so WIDTH+1 bits suffice
  always_comb begin
    r = rem_q;
    q = quo_q;
    ge = 1'b0;
    for (int i = 0; i < UNROLL; i++) begin
      r = {r[WIDTH-1:0], q[WIDTH-1]};
      ge = r >= {1'b0, dvs_q};
      r = ge ? r - {1'b0, dvs_q} : r;
      q = {q[WIDTH-2:0], ge};
    end
    q_fix = neg_q ? -q : q;
    r_fix = rsgn_q ? -r[WIDTH-1:0] : r[WIDTH-1:0];
  end
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    rem_d = rem_q;
    quo_d = quo_q;
    dvs_d = dvs_q;
    neg_d = neg_q;
    rsgn_d = rsgn_q;
    res_d = res_q;
    dz_d = dz_q;
    if (annul_in) begin
      state_d = IDLE;
      res_d = '0;
      dz_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: if (start_in) begin
          state_d = (opdata2_in == '0) ? BYZERO : ON;
          cnt_d = '0;
          rem_d = '0;
          quo_d = a_neg ? -opdata1_in : opdata1_in;
          dvs_d = b_neg ? -opdata2_in : opdata2_in;
          neg_d = a_neg ^ b_neg;
          rsgn_d = a_neg;
        end
        BYZERO: begin
          state_d = END;
          res_d = '0;
          dz_d = 1'b1;
        end
        ON: begin
          rem_d = r;
          quo_d = q;
          cnt_d = cnt_q + STEP;
          state_d = (cnt_q == LAST) ? END : ON;
          res_d = (cnt_q == LAST) ? {r_fix, q_fix} : res_q;
        end
        END: if (!start_in) begin
          state_d = IDLE;
          dz_d = 1'b0;
        end
        default: state_d = IDLE;
      endcase
    end
    ready_d = state_d == END;
    busy_d = (state_d == ON) || (state_d == BYZERO);
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      rem_q <= '0;
      quo_q <= '0;
      dvs_q <= '0;
      neg_q <= 1'b0;
      rsgn_q <= 1'b0;
      res_q <= '0;
      ready_q <= 1'b0;
      busy_q <= 1'b0;
      dz_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      rem_q <= rem_d;
      quo_q <= quo_d;
      dvs_q <= dvs_d;
      neg_q <= neg_d;
      rsgn_q <= rsgn_d;
      res_q <= res_d;
      ready_q <= ready_d;
      busy_q <= busy_d;
      dz_q <= dz_d;
    end
  end
  assign result_out = res_q;
  assign ready_out = ready_q;
  assign busy_out = busy_q;
  assign div_zero_out = dz_q;
endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: directed scoreboard bench for div_unit (32/1 and 16/4 instances).
module tb_div_unit;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;
  logic s32, a32, g32, rdy32, bsy32, dz32;
  logic [31:0] x32, y32;
  logic [63:0] res32;
  logic s16, a16, g16, rdy16, bsy16, dz16;
  logic [15:0] x16, y16;
  logic [31:0] res16;
  div_unit #(.WIDTH(32), .UNROLL(1)) u32 (
    .clk(clk), .rst(rst), .start_in(s32), .annul_in(a32), .signed_div_in(g32),
    .opdata1_in(x32), .opdata2_in(y32), .result_out(res32), .ready_out(rdy32),
    .busy_out(bsy32), .div_zero_out(dz32));
  div_unit #(.WIDTH(16), .UNROLL(4)) u16 (
    .clk(clk), .rst(rst), .start_in(s16), .annul_in(a16), .signed_div_in(g16),
    .opdata1_in(x16), .opdata2_in(y16), .result_out(res16), .ready_out(rdy16),
    .busy_out(bsy16), .div_zero_out(dz16));
  int tests = 0;
  int fails = 0;
  logic [64:0] q32[$];
  logic [32:0] q16[$];
  logic [64:0] e32;
  logic [32:0] e16;
  logic p32 = 1'b0;
  logic p16 = 1'b0;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask
  // monitors: each rising ready_out retires the oldest expected result
  always @(negedge clk) begin
    if (rdy32 && !p32) begin
      if (q32.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL ready32: unexpected ready_out=1, required 0");
      end else begin
        e32 = q32.pop_front();
        chk("result32", res32, e32[63:0]);
        chk("div_zero32", 64'(dz32), 64'(e32[64]));
      end
    end
    p32 = rdy32;
  end
  always @(negedge clk) begin
    if (rdy16 && !p16) begin
      if (q16.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL ready16: unexpected ready_out=1, required 0");
      end else begin
        e16 = q16.pop_front();
        chk("result16", 64'(res16), 64'(e16[31:0]));
        chk("div_zero16", 64'(dz16), 64'(e16[32]));
      end
    end
    p16 = rdy16;
  end
  task automatic drive(input bit w, input logic st, input logic [31:0] a, input logic [31:0] b, input logic sg);
    if (w) begin
      s16 = st; x16 = a[15:0]; y16 = b[15:0]; g16 = sg;
    end else begin
      s32 = st; x32 = a; y32 = b; g32 = sg;
    end
  endtask
  // operands are scrambled mid-operation to prove they were latched
  task automatic op(input bit w, input logic [31:0] a, input logic [31:0] b, input logic sg,
                    input logic [63:0] exp, input logic edz, input int lat, input bit drop);
    int n = 0;
    int nb = 0;
    @(negedge clk);
    drive(w, 1'b1, a, b, sg);
    if (w) q16.push_back({edz, exp[31:0]});
    else q32.push_back({edz, exp});
    do begin
      @(negedge clk);
      n++;
      if (n == 3) drive(w, 1'b1, ~a, b + 5, ~sg);
      if (n == 5 && drop) drive(w, 1'b0, ~a, b + 5, ~sg);
      nb += int'(w ? bsy16 : bsy32);
    end while (!(w ? rdy16 : rdy32) && n < 200);
    chk("latency", 64'(n), 64'(lat));
    chk("busy cycles", 64'(nb), 64'(lat - 1));
    chk("busy at ready", 64'(w ? bsy16 : bsy32), 64'd0);
    if (!drop) begin
      repeat (2) @(negedge clk);
      chk("ready held", 64'(w ? rdy16 : rdy32), 64'd1);
      drive(w, 1'b0, a, b, sg);
    end
    @(negedge clk);
    chk("ready cleared", 64'(w ? rdy16 : rdy32), 64'd0);
    chk("div_zero cleared", 64'(w ? dz16 : dz32), 64'd0);
  endtask
  initial begin
    s32 = 0; a32 = 0; g32 = 0; x32 = '0; y32 = '0;
    s16 = 0; a16 = 0; g16 = 0; x16 = '0; y16 = '0;
    rst = 1'b1;
    #1 rst = 1'b0;
    #2;
    chk("reset result32", res32, 64'd0);
    chk("reset flags32", {61'd0, rdy32, bsy32, dz32}, 64'd0);
    chk("reset result16", 64'(res16), 64'd0);
    chk("reset flags16", {61'd0, rdy16, bsy16, dz16}, 64'd0);
    @(negedge clk);
    rst = 1'b1;
    op(0, 32'd100, 32'd7, 0, {32'h2, 32'hE}, 0, 33, 0);
    op(0, 32'hFFFFFFF9, 32'h2, 1, {32'hFFFFFFFF, 32'hFFFFFFFD}, 0, 33, 0);
    op(0, 32'h7, 32'hFFFFFFFE, 1, {32'h1, 32'hFFFFFFFD}, 0, 33, 0);
    op(0, 32'h12345678, 32'h0, 0, 64'd0, 1, 2, 0);
    op(0, 32'hFFFFFFFF, 32'h10, 0, {32'hF, 32'h0FFFFFFF}, 0, 33, 1);
    op(0, 32'h80000000, 32'hFFFFFFFF, 1, {32'h0, 32'h80000000}, 0, 33, 0);
    op(1, 32'h8000, 32'hFFFF, 1, {32'h0, 16'h0000, 16'h8000}, 0, 5, 0);
    op(1, 32'h8000, 32'hFFFF, 0, {32'h0, 16'h8000, 16'h0000}, 0, 5, 0);
    op(1, 32'hFF9C, 32'h0007, 1, {32'h0, 16'hFFFE, 16'hFFF2}, 0, 5, 0);
    // annul sampled on the 10th edge after acceptance
    @(negedge clk);
    drive(0, 1'b1, 32'd100, 32'd7, 0);
    repeat (9) @(negedge clk);
    a32 = 1'b1;
    drive(0, 1'b0, 32'd100, 32'd7, 0);
    @(negedge clk);
    a32 = 1'b0;
    chk("annul busy", 64'(bsy32), 64'd0);
    chk("annul ready", 64'(rdy32), 64'd0);
    chk("annul result", res32, 64'd0);
    repeat (40) @(negedge clk);
    op(0, 32'd1000, 32'd10, 0, {32'd0, 32'd100}, 0, 33, 0);
    // asynchronous reset between clock edges while ON
    @(negedge clk);
    drive(0, 1'b1, 32'd500, 32'd7, 0);
    repeat (5) @(negedge clk);
    chk("busy before reset", 64'(bsy32), 64'd1);
    #2 rst = 1'b0;
    #1;
    chk("async reset busy", 64'(bsy32), 64'd0);
    chk("async reset ready", 64'(rdy32), 64'd0);
    chk("async reset result", res32, 64'd0);
    drive(0, 1'b0, 32'd500, 32'd7, 0);
    @(negedge clk);
    rst = 1'b1;
    op(0, 32'd9, 32'd3, 0, {32'd0, 32'd3}, 0, 33, 0);
    repeat (3) @(negedge clk);
    chk("scoreboard drained", 64'(q32.size() + q16.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
